sipo_word_feeder: RTL and testbench

// Upstream stage for the 8-bit serial-in/parallel-out shift register model. Accepts parallel

---
 rtl/sipo_feeder_pkg.sv | 22 ++
 rtl/sipo_word_feeder_if.sv | 32 +++
 rtl/sipo_feeder_holdbuf.sv | 61 ++++++
 rtl/sipo_word_feeder.sv | 115 +++++++++++
 tb/tb_sipo_word_feeder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_feeder_pkg.sv
// Shared definitions for the SIPO word feeder: state encoding, default
// output delay and the bit-count width helper.
`timescale 1ns/1ps
package sipo_feeder_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Board-level output propagation delay in ns (used with SIPO_FEEDER_DELAY_EN).
  localparam int FEEDER_DLY_NS = 19;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } feeder_state_e;

  // Width of the bit counter for a given word width.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_word_feeder_if.sv
// Bus between a word source and the feeder: parallel input handshake plus
// the serial/qualifier outputs that drive the downstream shift register.
//
// Handshake: a word transfers on the posedge where din_valid and din_ready
// are both 1. din_ready depends only on the feeder's own holding buffer,
// never on din_valid. While din_valid is 1 and din_ready is 0 the source
// must hold din stable; din is ignored whenever din_ready is 0.
`timescale 1ns/1ps
interface sipo_word_feeder_if #(parameter int WIDTH = 8);
  import sipo_feeder_pkg::*;

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_a;
  logic             ser_b;
  logic             shift_en;
  logic             word_strobe;
  logic             busy;
  feeder_state_e    state_dbg;

  modport master (
    output din, din_valid,
    input  din_ready, ser_a, ser_b, shift_en, word_strobe, busy, state_dbg
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_a, ser_b, shift_en, word_strobe, busy, state_dbg
  );

endinterface

// File: rtl/sipo_feeder_holdbuf.sv
// One-entry holding buffer in front of the shifter. Accepts a word when
// empty; the shifter empties it with pop. Optional output delay is enabled
// by the SIPO_FEEDER_DELAY_EN macro.
`timescale 1ns/1ps
`ifndef SIPO_FEEDER_NBA
`ifdef SIPO_FEEDER_DELAY_EN
`define SIPO_FEEDER_NBA #(OUT_DLY)
`else
`define SIPO_FEEDER_NBA
`endif
`endif
module sipo_feeder_holdbuf
  import sipo_feeder_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef SIPO_FEEDER_DELAY_EN
  , parameter int OUT_DLY = FEEDER_DLY_NS
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // Next buffer contents: pop empties, an accepted push fills.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (push_valid && !full_q) begin
      data_d = push_data;
      full_d = 1'b1;
    end
  end

  // Buffer registers; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= `SIPO_FEEDER_NBA '0;
      full_q <= `SIPO_FEEDER_NBA 1'b0;
    end else begin
      data_q <= `SIPO_FEEDER_NBA data_d;
      full_q <= `SIPO_FEEDER_NBA full_d;
    end
  end

  assign push_ready = ~full_q;
  assign data       = data_q;
  assign full       = full_q;

endmodule

// File: rtl/sipo_word_feeder.sv
// Serialises parallel words MSB first onto an 8-bit SIPO register's A/B
// inputs, with a clock qualifier and a one-cycle word strobe for the
// downstream output latch. Defining SIPO_FEEDER_DELAY_EN adds an OUT_DLY ns
// delay to every registered output, including the MR clear.
`timescale 1ns/1ps
`ifndef SIPO_FEEDER_NBA
`ifdef SIPO_FEEDER_DELAY_EN
`define SIPO_FEEDER_NBA #(OUT_DLY)
`else
`define SIPO_FEEDER_NBA
`endif
`endif
module sipo_word_feeder
  import sipo_feeder_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef SIPO_FEEDER_DELAY_EN
  , parameter int OUT_DLY = FEEDER_DLY_NS
`endif
) (
  input  logic                clk,
  input  logic                MR,
  sipo_word_feeder_if.slave   bus
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  feeder_state_e    state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             hold_pop;
  logic             last_bit;

  sipo_feeder_holdbuf #(
    .WIDTH   (WIDTH)
`ifdef SIPO_FEEDER_DELAY_EN
    , .OUT_DLY (OUT_DLY)
`endif
  ) u_holdbuf (
    .clk        (clk),
    .rst        (MR),
    .push_data  (bus.din),
    .push_valid (bus.din_valid),
    .push_ready (bus.din_ready),
    .pop        (hold_pop),
    .data       (hold_data),
    .full       (hold_full)
  );

  assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

  // Next state: load from the buffer when idle, shift while busy, and on the
  // last bit either reload (buffer full) or go idle; the strobe flags the
  // edge that clocked the last bit.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    hold_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_full) begin
          state_d  = S_SHIFT;
          shift_d  = hold_data;
          cnt_d    = '0;
          hold_pop = 1'b1;
        end
      end
      S_SHIFT: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          if (hold_full) begin
            shift_d  = hold_data;
            hold_pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, shifter, counter and strobe registers; MR discards a word in flight.
  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      state_q  <= `SIPO_FEEDER_NBA S_IDLE;
      shift_q  <= `SIPO_FEEDER_NBA '0;
      cnt_q    <= `SIPO_FEEDER_NBA '0;
      strobe_q <= `SIPO_FEEDER_NBA 1'b0;
    end else begin
      state_q  <= `SIPO_FEEDER_NBA state_d;
      shift_q  <= `SIPO_FEEDER_NBA shift_d;
      cnt_q    <= `SIPO_FEEDER_NBA cnt_d;
      strobe_q <= `SIPO_FEEDER_NBA strobe_d;
    end
  end

  assign bus.ser_a       = (state_q == S_SHIFT) & shift_q[WIDTH-1];
  assign bus.ser_b       = (state_q == S_SHIFT);
  assign bus.shift_en    = (state_q == S_SHIFT);
  assign bus.word_strobe = strobe_q;
  assign bus.busy        = (state_q == S_SHIFT) | hold_full;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sipo_word_feeder.sv
// Bench for sipo_word_feeder: directed word streams, a word-level model of
// the feeder, a model of the downstream 74164 register, and a scoreboard of
// accepted words checked at every word strobe.
`timescale 1ns/1ps
module tb_sipo_word_feeder;
  import sipo_feeder_pkg::*;

  localparam int WIDTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic mr  = 1'b1;
  always #25 clk = ~clk;

  sipo_word_feeder_if #(.WIDTH(WIDTH)) bus ();

  sipo_word_feeder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .MR  (mr),
    .bus (bus.slave)
  );

  logic [WIDTH-1:0] din       = '0;
  logic             din_valid = 1'b0;
  assign bus.din       = din;
  assign bus.din_valid = din_valid;

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  logic [WIDTH-1:0] stim[$];
  logic             bits_hist[$];
  int               runs_q[$];
  int               st_cyc[$];
  int               run_cur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- word-level feeder model ----------------
  // m_left counts bits of the current word still to appear on ser_a.
  logic             m_full   = 1'b0;
  logic [WIDTH-1:0] m_buf    = '0;
  logic [WIDTH-1:0] m_cur    = '0;
  int               m_left   = 0;
  logic             m_strobe = 1'b0;

  always @(posedge clk or posedge mr) begin
    if (mr) begin
      m_full   = 1'b0;
      m_left   = 0;
      m_strobe = 1'b0;
      exp_q.delete();
    end else begin : model_step
      bit acc;
      acc      = din_valid && !m_full;
      m_strobe = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) m_strobe = 1'b1;
      end
      if (m_left == 0 && m_full) begin
        m_cur  = m_buf;
        m_left = WIDTH;
        m_full = 1'b0;
      end
      if (acc) begin
        m_buf  = din;
        m_full = 1'b1;
        exp_q.push_back(din);
      end
    end
  end

  // ---------------- downstream 74164 model ----------------
  logic [WIDTH-1:0] sr74 = '0;
  always @(posedge clk) begin
    if (bus.shift_en) sr74 <= {sr74[WIDTH-2:0], bus.ser_a & bus.ser_b};
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic exp_a;
    exp_a = (m_left != 0) ? m_cur[m_left-1] : 1'b0;
    check("din_ready",   bus.din_ready,   !m_full);
    check("ser_a",       bus.ser_a,       exp_a);
    check("ser_b",       bus.ser_b,       m_left != 0);
    check("shift_en",    bus.shift_en,    m_left != 0);
    check("word_strobe", bus.word_strobe, m_strobe);
    check("busy",        bus.busy,        (m_left != 0) || m_full);
    check("state_dbg",   bus.state_dbg == S_SHIFT, m_left != 0);
    if (bus.shift_en) begin
      bits_hist.push_back(bus.ser_a);
      run_cur++;
    end else if (run_cur != 0) begin
      runs_q.push_back(run_cur);
      run_cur = 0;
    end
    if (bus.word_strobe) begin
      st_cyc.push_back(cyc);
      got_q.push_back(sr74);
      if (exp_q.size() == 0) check("strobe_without_word", 1, 0);
      else check("latched_word", sr74, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Offers every word in stim with din_valid held, one after another.
  task automatic send_stim();
    @(negedge clk); #1;
    foreach (stim[i]) begin
      int n;
      n = 0;
      din       = stim[i];
      din_valid = 1'b1;
      while (!bus.din_ready && n < 40) begin
        @(negedge clk); #1;
        n++;
      end
      if (n >= 40) check("accept_timeout", 0, 1);
      @(negedge clk); #1;
    end
    din_valid = 1'b0;
    din       = WIDTH'($urandom_range(0, 255));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int b0, r0, s0, n, k;
    logic [WIDTH-1:0] bits;

    // 1: reset with random inputs
    repeat (4) begin
      @(negedge clk); #1;
      din       = WIDTH'($urandom_range(0, 255));
      din_valid = 1'($urandom_range(0, 1));
    end
    check("rst_din_ready",   bus.din_ready,   1);
    check("rst_ser_a",       bus.ser_a,       0);
    check("rst_ser_b",       bus.ser_b,       0);
    check("rst_shift_en",    bus.shift_en,    0);
    check("rst_word_strobe", bus.word_strobe, 0);
    check("rst_busy",        bus.busy,        0);
    din_valid = 1'b0;
    mr        = 1'b0;
    idle(2);

    // 2: single word A5
    b0 = bits_hist.size();
    stim = '{8'hA5};
    send_stim();
    idle(14);
    check("a5_shift_cycles", bits_hist.size() - b0, 8);
    bits = '0;
    for (int i = 0; i < 8 && (b0 + i) < bits_hist.size(); i++) bits = {bits[6:0], bits_hist[b0+i]};
    check("a5_serial_bits", bits, 8'hA5);

    // 3: back-to-back 3C, FF
    r0 = runs_q.size();
    s0 = st_cyc.size();
    stim = '{8'h3C, 8'hFF};
    send_stim();
    idle(20);
    check("b2b_run_len", (runs_q.size() > r0) ? runs_q[r0] : 0, 16);
    check("b2b_strobes", st_cyc.size() - s0, 2);
    check("b2b_strobe_gap", (st_cyc.size() >= s0 + 2) ? st_cyc[s0+1] - st_cyc[s0] : 0, 8);

    // 4: backpressure with four queued words
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_stim();
    idle(20);

    // 5: mid-word reset during 81, then 55
    stim = '{8'h81};
    send_stim();
    n = 0; k = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      if (bus.shift_en) k++;
      n++;
    end
    if (n >= 40) check("mid_rst_timeout", 0, 1);
    #2 mr = 1'b1;
    #21;
    check("mrst_din_ready",   bus.din_ready,   1);
    check("mrst_ser_a",       bus.ser_a,       0);
    check("mrst_ser_b",       bus.ser_b,       0);
    check("mrst_shift_en",    bus.shift_en,    0);
    check("mrst_word_strobe", bus.word_strobe, 0);
    check("mrst_busy",        bus.busy,        0);
    @(negedge clk); #1;
    mr = 1'b0;
    idle(2);
    stim = '{8'h55};
    send_stim();
    idle(14);

    // literal word order pins the model and scoreboard
    check("words_latched", got_q.size(), 8);
    if (got_q.size() == 8) begin
      check("w0", got_q[0], 8'hA5);
      check("w1", got_q[1], 8'h3C);
      check("w2", got_q[2], 8'hFF);
      check("w3", got_q[3], 8'h11);
      check("w4", got_q[4], 8'h22);
      check("w5", got_q[5], 8'h33);
      check("w6", got_q[6], 8'h44);
      check("w7", got_q[7], 8'h55);
    end
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
